// File: rtl/nn_pkg.sv
// Shared neural-network constants and the layer sequencer state encoding.
package nn_pkg;

  localparam int NN_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/layer_sequencer.sv
// Steps one shared dot-product neuron through every row of a layer's weight memory.
// Optional LAYER_SEQ_RELU_EN clamps negative neuron results to zero on write-back.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int INPUT_WIDTH = 3,
  parameter int NUM_NEURONS = 4,
  parameter int DATA_WIDTH  = NN_DATA_WIDTH,
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0]   x_in,
  output logic [AW-1:0]                            w_addr,
  input  logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH-1:0]                    b_data,
  output logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0]   n_a,
  output logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0]   n_w,
  output logic [DATA_WIDTH-1:0]                    n_bias,
  output logic                                     n_valid_o,
  input  logic                                     n_valid_i,
  input  logic [DATA_WIDTH-1:0]                    n_result,
  output logic                                     busy,
  output logic                                     done,
  output logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]   y_out
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);

  seq_state_e                                state_q, state_d;
  logic [AW-1:0]                             idx_q, idx_d;
  logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0]    x_q, x_d;
  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]    y_q, y_d;
  logic [DATA_WIDTH-1:0]                     wr_val;

`ifdef LAYER_SEQ_RELU_EN
  assign wr_val = n_result[DATA_WIDTH-1] ? '0 : n_result;
`else
  assign wr_val = n_result;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x_in;
          idx_d   = '0;
          y_d     = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      // Result write and index advance share the WAIT exit edge.
      S_WAIT: begin
        if (n_valid_i) begin
          y_d[idx_q] = wr_val;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands are zeroed outside ISSUE so reset and idle present a quiet bus.
  always_comb begin
    n_a       = '0;
    n_w       = '0;
    n_bias    = '0;
    n_valid_o = 1'b0;
    if (state_q == S_ISSUE) begin
      n_a       = x_q;
      n_w       = w_data;
      n_bias    = b_data;
      n_valid_o = 1'b1;
    end
  end

  assign w_addr = idx_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign y_out  = y_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a 2-neuron layer, a 1-cycle weight ROM and a 1-cycle neuron.
module tb_layer_sequencer;

  localparam int IW = 3;
  localparam int NN = 2;
  localparam int DW = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [IW-1:0][DW-1:0]   x_in = '0;
  logic [0:0]              w_addr;
  logic [IW-1:0][DW-1:0]   w_data;
  logic [DW-1:0]           b_data;
  logic [IW-1:0][DW-1:0]   n_a, n_w;
  logic [DW-1:0]           n_bias;
  logic                    n_valid_o, n_valid_i;
  logic [DW-1:0]           n_result;
  logic                    busy, done;
  logic [NN-1:0][DW-1:0]   y_out;

  layer_sequencer #(.INPUT_WIDTH(IW), .NUM_NEURONS(NN), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .w_addr(w_addr), .w_data(w_data), .b_data(b_data),
    .n_a(n_a), .n_w(n_w), .n_bias(n_bias), .n_valid_o(n_valid_o),
    .n_valid_i(n_valid_i), .n_result(n_result),
    .busy(busy), .done(done), .y_out(y_out)
  );

  always #5 clk = ~clk;

  // Weight/bias ROM, registered read.
  logic [IW-1:0][DW-1:0] rom_w [NN];
  logic [DW-1:0]         rom_b [NN];
  always @(posedge clk) begin
    w_data <= rom_w[w_addr];
    b_data <= rom_b[w_addr];
  end

  // Neuron: result one cycle after issue, plus stall_n0 extra cycles for neuron 0.
  int          stall_n0 = 0;
  logic        pend;
  int          cnt;
  logic [DW-1:0] res;
  logic        force_vld = 1'b0;
  logic [DW-1:0] force_res = '0;

  function automatic logic [DW-1:0] dot(input logic [IW-1:0][DW-1:0] a,
                                        input logic [IW-1:0][DW-1:0] w,
                                        input logic [DW-1:0] b);
    int s;
    s = int'($signed(b));
    for (int i = 0; i < IW; i++) s += int'($signed(a[i])) * int'($signed(w[i]));
    return s[DW-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; cnt <= 0; res <= '0;
    end else if (n_valid_o) begin
      pend <= 1'b1;
      cnt  <= (w_addr == 1'b0) ? stall_n0 : 0;
      res  <= dot(n_a, n_w, n_bias);
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end
  end

  assign n_valid_i = (pend && cnt == 0) || force_vld;
  assign n_result  = force_vld ? force_res : res;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0]           nv_vec, dn_vec;
  logic                  busy1;
  logic [NN-1:0][DW-1:0] y_c1;
  logic [IW-1:0][DW-1:0] na_c2;
  logic [DW-1:0]         nb_c2;

  // Start pulse sampled at edge 0; records cycles 1..ncyc; extra start pulses in cycles sa/sb.
  task automatic run_layer(input int ncyc, input int sa, input int sb);
    nv_vec = '0; dn_vec = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      nv_vec[c] = n_valid_o;
      dn_vec[c] = done;
      if (c == 1) begin busy1 = busy; y_c1 = y_out; end
      if (c == 2) begin na_c2 = n_a; nb_c2 = n_bias; end
      start = (c == sa || c == sb);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  logic [DW-1:0] exp_y1, exp_y1b;
  logic [IW-1:0][DW-1:0] x0, x1;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef LAYER_SEQ_RELU_EN
    exp_y1  = 16'h0000;
    exp_y1b = 16'h0000;
`else
    exp_y1  = 16'hFFFF;
    exp_y1b = 16'hFFFE;
`endif
    rom_w[0] = {16'd1, 16'd1, 16'd1};           rom_b[0] = 16'd4;
    rom_w[1] = {16'd0, 16'd0, 16'hFFFF};         rom_b[1] = 16'd0;
    x0 = {16'd3, 16'd2, 16'd1};
    x1 = {16'hFFFF, 16'd0, 16'd2};
    x_in = x0;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nvalid", n_valid_o, 0);
    check("rst_waddr", w_addr, 0);
    check("rst_yout", y_out, 0);
    check("rst_operands", {n_a, n_w, n_bias}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Spurious neuron response while idle
    force_vld = 1'b1; force_res = 16'd7;
    @(posedge clk); #1;
    force_vld = 1'b0;
    check("idle_spur_y", y_out, 0);
    check("idle_spur_busy", busy, 0);

    // Basic layer
    run_layer(10, 0, 0);
    check("l1_busy_c1", busy1, 1);
    check("l1_nvalid_cycles", nv_vec, 32'h24);
    check("l1_done_cycles", dn_vec, 32'h80);
    check("l1_na_c2", na_c2, x0);
    check("l1_nbias_c2", nb_c2, 16'd4);
    check("l1_y0", y_out[0], 16'd10);
    check("l1_y1", y_out[1], exp_y1);
    repeat (3) @(posedge clk);
    #1;
    check("l1_hold_busy", busy, 0);
    check("l1_hold_y", y_out, {exp_y1, 16'd10});

    // Start pulses during the layer are ignored; y_out cleared at accepted start
    run_layer(10, 3, 4);
    check("l2_y_cleared_c1", y_c1, 0);
    check("l2_nvalid_cycles", nv_vec, 32'h24);
    check("l2_done_cycles", dn_vec, 32'h80);
    check("l2_y", y_out, {exp_y1, 16'd10});
    check("l2_no_restart_busy", busy, 0);

    // Neuron 0 stalled five extra cycles
    stall_n0 = 5;
    run_layer(15, 0, 0);
    stall_n0 = 0;
    check("l3_nvalid_cycles", nv_vec, 32'h404);
    check("l3_done_cycles", dn_vec, 32'h1000);
    check("l3_y", y_out, {exp_y1, 16'd10});

    // Reset asserted in cycle 4 of a layer
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("l4_y0_before_rst", y_out[0], 16'd10);
    rst_n = 1'b0;
    #1;
    check("l4_rst_busy", busy, 0);
    check("l4_rst_outputs", {done, n_valid_o, w_addr, n_a, n_w, n_bias}, 0);
    check("l4_rst_y", y_out, 0);
    dn_vec = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      dn_vec[i] = done;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 3; i < 6; i++) begin
      @(posedge clk); #1;
      dn_vec[i] = done;
    end
    check("l4_no_done", dn_vec, 0);

    // Fresh layer after release with a new input vector
    x_in = x1;
    run_layer(10, 0, 0);
    check("l5_nvalid_cycles", nv_vec, 32'h24);
    check("l5_done_cycles", dn_vec, 32'h80);
    check("l5_y0", y_out[0], 16'd5);
    check("l5_y1", y_out[1], exp_y1b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 3, number of activations and weights per neuron.
REQ-002 SHALL have parameter NUM_NEURONS, default 4, number of neurons sequenced through one shared dot-product datapath.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, signed activation, weight, bias and result width.
REQ-004 SHALL have port clk, input, 1, clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, layer start request.
REQ-007 SHALL have port x_in, input, INPUT_WIDTH x DATA_WIDTH signed, layer input vector.
REQ-008 SHALL have port w_addr, output, $clog2(NUM_NEURONS) (min 1), weight/bias memory address equal to the current neuron index.
REQ-009 SHALL have port w_data, input, INPUT_WIDTH x DATA_WIDTH signed, weight row, valid one cycle after w_addr.
REQ-010 SHALL have port b_data, input, DATA_WIDTH signed, bias, same timing as w_data.
REQ-011 SHALL have ports n_a, n_w (output, INPUT_WIDTH x DATA_WIDTH) and n_bias (output, DATA_WIDTH), driving the shared neuron datapath.
REQ-012 SHALL have port n_valid_o, output, 1, one-cycle issue strobe to the neuron.
REQ-013 SHALL have ports n_valid_i (input, 1) and n_result (input, DATA_WIDTH signed), returned from the neuron.
REQ-014 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and y_out (output, NUM_NEURONS x DATA_WIDTH signed, layer results).

Function
REQ-015 SHALL implement states IDLE, FETCH, ISSUE, WAIT and DONE.
REQ-016 In IDLE with start=1: SHALL capture x_in into an internal register, set the neuron index to 0, clear y_out, and go to FETCH.
REQ-017 In FETCH: SHALL drive w_addr=index and go to ISSUE unconditionally.
REQ-018 In ISSUE: SHALL drive n_a=captured x, n_w=w_data, n_bias=b_data and n_valid_o=1 for exactly this cycle, then go to WAIT.
REQ-019 In WAIT: SHALL hold until n_valid_i=1, then write n_result into y_out[index].
REQ-020 On leaving WAIT: SHALL go to DONE if index=NUM_NEURONS-1; otherwise SHALL increment index and go to FETCH.
REQ-021 In DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-022 With a 1-cycle neuron and start sampled at edge 0: each neuron SHALL take 3 cycles, and done SHALL be high in cycle 3*NUM_NEURONS+1.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 start while busy=1 SHALL be ignored, with no restart and no queueing.
REQ-025 n_valid_i outside WAIT SHALL be ignored.
REQ-026 y_out SHALL hold its value from DONE until the next accepted start.
REQ-027 n_a, n_w and n_bias MAY hold any value whenever n_valid_o=0.
REQ-028 y_out entries SHALL be written as DATA_WIDTH bits, with no extension and no saturation.

Reset
REQ-029 While rst_n=0: state SHALL be IDLE, index 0, and busy, done, n_valid_o, w_addr, y_out, n_a, n_w and n_bias all 0.
REQ-030 Reset asserted mid-layer SHALL abort immediately, with no done pulse and results discarded.
REQ-031 After reset deasserts, the first accepted start SHALL begin a fresh layer.

Configuration
REQ-032 With macro LAYER_SEQ_RELU_EN defined: SHALL write 0 to y_out[index] when n_result is negative, otherwise n_result.
REQ-033 With LAYER_SEQ_RELU_EN undefined: SHALL write n_result unmodified; no ReLU logic SHALL be present.

Structure
REQ-034 Shared package nn_pkg SHALL hold the default DATA_WIDTH constant and the sequencer state enum typedef.
REQ-035 SHALL contain no sub-module; the neuron datapath and the weight memory are instantiated by the parent and connected through the ports above.

Verification (INPUT_WIDTH=3, NUM_NEURONS=2, 1-cycle neuron, 1-cycle ROM)
REQ-036 x=(1,2,3), row0=(1,1,1), b0=4, start at edge 0 -> n_valid_o high in cycles 2 and 5; y_out[0]=10; done high in cycle 7 only.
REQ-037 row1=(-1,0,0), b1=0: without LAYER_SEQ_RELU_EN -> y_out[1]=16'hFFFF; with it -> y_out[1]=0.
REQ-038 start pulsed in cycles 3 and 4 during the layer -> no restart; done still in cycle 7; y_out unchanged versus REQ-036.
REQ-039 Neuron stalled by delaying n_valid_i 5 cycles in WAIT -> FSM holds WAIT; done delayed by exactly 5 cycles.
REQ-040 rst_n=0 in cycle 4 -> all outputs 0 in that cycle; no done pulse; new start after release -> correct results.
REQ-041 Spurious n_valid_i=1 in IDLE with n_result=7 -> y_out unchanged and busy stays 0.
